// File: rtl/aibcr3_4to2enc_if.sv
// rtl/aibcr3_4to2enc_if.sv - readback/control bundle for the 4-to-2 thermometer encoder
interface aibcr3_4to2enc_if;
    logic       enable;
    logic       sample_req;
    logic [3:0] nsel_inb;
    logic [3:0] psel_in;
    logic [1:0] nsel_code;
    logic [1:0] psel_code;
    logic       code_vld;
    logic       therm_err;
    logic       np_mismatch;
    logic       timeout_err;
    logic       busy;

    modport master (
        output enable, sample_req, nsel_inb, psel_in,
        input  nsel_code, psel_code, code_vld, therm_err, np_mismatch, timeout_err, busy
    );

    modport slave (
        input  enable, sample_req, nsel_inb, psel_in,
        output nsel_code, psel_code, code_vld, therm_err, np_mismatch, timeout_err, busy
    );
endinterface

// File: rtl/aibcr3_4to2enc.sv
// rtl/aibcr3_4to2enc.sv - settle/filter/encode of n/p thermometer readbacks into 2-bit codes
module aibcr3_4to2enc #(
    parameter int SETTLE_CYC = 4,
    parameter int STABLE_CNT = 3,
    parameter int TIMEOUT    = 64
) (
    input logic              clk,
    input logic              reset,
    aibcr3_4to2enc_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        FILTER = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
    localparam logic [2:0] STABLE_W    = 3'(STABLE_CNT);
    localparam logic [7:0] TIMEOUT_W   = 8'(TIMEOUT);

    state_t     state, state_nxt;
    logic [3:0] settle_cnt, settle_cnt_nxt;
    logic [2:0] stable_cnt, stable_cnt_nxt;
    logic [7:0] filt_cnt, filt_cnt_nxt;
    logic [3:0] n_prev, n_prev_nxt;
    logic [3:0] p_prev, p_prev_nxt;
    logic [1:0] nsel_code, nsel_code_nxt;
    logic [1:0] psel_code, psel_code_nxt;
    logic       code_vld, code_vld_nxt;
    logic       therm_err, therm_err_nxt;
    logic       np_mismatch, np_mismatch_nxt;
    logic       timeout_err, timeout_err_nxt;

    logic [3:0] n_pat;
    logic [3:0] p_pat;
    logic [2:0] stable_inc;
    logic [7:0] filt_inc;

    // The n leg reads back inverted; normalise so both legs share one encoder.
    assign n_pat = ~bus.nsel_inb;
    assign p_pat = bus.psel_in;

    function automatic logic pat_legal(input logic [3:0] pat);
        case (pat)
            4'b0001, 4'b0011, 4'b0111, 4'b1111: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] pat_code(input logic [3:0] pat);
        case (pat)
            4'b0011: return 2'b01;
            4'b0111: return 2'b10;
            4'b1111: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // Run-length of identical samples and FILTER dwell, precomputed for the FSM.
    always_comb begin
        if (stable_cnt == 3'd0 || n_pat != n_prev || p_pat != p_prev) begin
            stable_inc = 3'd1;
        end else begin
            stable_inc = stable_cnt + 3'd1;
        end
        filt_inc = filt_cnt + 8'd1;
    end

    // Next-state and next-output logic; everything holds unless a state acts on it.
    always_comb begin
        state_nxt       = state;
        settle_cnt_nxt  = settle_cnt;
        stable_cnt_nxt  = stable_cnt;
        filt_cnt_nxt    = filt_cnt;
        n_prev_nxt      = n_prev;
        p_prev_nxt      = p_prev;
        nsel_code_nxt   = nsel_code;
        psel_code_nxt   = psel_code;
        code_vld_nxt    = 1'b0;
        therm_err_nxt   = therm_err;
        np_mismatch_nxt = np_mismatch;
        timeout_err_nxt = timeout_err;

        if (state != IDLE && !bus.enable) begin
            // Abort: drop back quietly, leaving codes and flags as they were.
            state_nxt      = IDLE;
            settle_cnt_nxt = 4'd0;
            stable_cnt_nxt = 3'd0;
            filt_cnt_nxt   = 8'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    settle_cnt_nxt = 4'd0;
                    stable_cnt_nxt = 3'd0;
                    filt_cnt_nxt   = 8'd0;
                    if (bus.sample_req && bus.enable) begin
                        state_nxt       = SETTLE;
                        therm_err_nxt   = 1'b0;
                        np_mismatch_nxt = 1'b0;
                        timeout_err_nxt = 1'b0;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state_nxt      = FILTER;
                        settle_cnt_nxt = 4'd0;
                        stable_cnt_nxt = 3'd0;
                        filt_cnt_nxt   = 8'd0;
                    end else begin
                        settle_cnt_nxt = settle_cnt + 4'd1;
                    end
                end
                FILTER: begin
                    n_prev_nxt     = n_pat;
                    p_prev_nxt     = p_pat;
                    stable_cnt_nxt = stable_inc;
                    filt_cnt_nxt   = filt_inc;
                    if (stable_inc == STABLE_W) begin
                        // Acceptance wins over a timeout landing on the same cycle.
                        state_nxt = DONE;
                        if (pat_legal(n_pat) && pat_legal(p_pat)) begin
                            nsel_code_nxt   = pat_code(n_pat);
                            psel_code_nxt   = pat_code(p_pat);
                            code_vld_nxt    = 1'b1;
                            np_mismatch_nxt = np_mismatch | (pat_code(n_pat) != pat_code(p_pat));
                        end else begin
                            therm_err_nxt = 1'b1;
                        end
                    end else if (filt_inc == TIMEOUT_W) begin
                        state_nxt       = IDLE;
                        timeout_err_nxt = 1'b1;
                        stable_cnt_nxt  = 3'd0;
                        filt_cnt_nxt    = 8'd0;
                    end
                end
                DONE: begin
                    state_nxt      = IDLE;
                    stable_cnt_nxt = 3'd0;
                    filt_cnt_nxt   = 8'd0;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // State and registered outputs; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            settle_cnt  <= 4'd0;
            stable_cnt  <= 3'd0;
            filt_cnt    <= 8'd0;
            n_prev      <= 4'd0;
            p_prev      <= 4'd0;
            nsel_code   <= 2'b00;
            psel_code   <= 2'b00;
            code_vld    <= 1'b0;
            therm_err   <= 1'b0;
            np_mismatch <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            settle_cnt  <= settle_cnt_nxt;
            stable_cnt  <= stable_cnt_nxt;
            filt_cnt    <= filt_cnt_nxt;
            n_prev      <= n_prev_nxt;
            p_prev      <= p_prev_nxt;
            nsel_code   <= nsel_code_nxt;
            psel_code   <= psel_code_nxt;
            code_vld    <= code_vld_nxt;
            therm_err   <= therm_err_nxt;
            np_mismatch <= np_mismatch_nxt;
            timeout_err <= timeout_err_nxt;
        end
    end

    assign bus.nsel_code   = nsel_code;
    assign bus.psel_code   = psel_code;
    assign bus.code_vld    = code_vld;
    assign bus.therm_err   = therm_err;
    assign bus.np_mismatch = np_mismatch;
    assign bus.timeout_err = timeout_err;
    assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_aibcr3_4to2enc.sv
// tb/tb_aibcr3_4to2enc.sv - self-checking bench for aibcr3_4to2enc
module tb_aibcr3_4to2enc;

    localparam int SETTLE_CYC = 4;
    localparam int STABLE_CNT = 3;
    localparam int TIMEOUT    = 64;

    logic clk;
    logic reset;
    logic chk_on;
    int   n_cmp;
    int   n_fail;

    aibcr3_4to2enc_if bus_if();

    aibcr3_4to2enc #(
        .SETTLE_CYC (SETTLE_CYC),
        .STABLE_CNT (STABLE_CNT),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: request age plus a history of FILTER samples.
    logic [1:0] m_n, m_p;
    logic       m_vld, m_te, m_nm, m_to;
    logic       m_active, m_done;
    int         m_age;
    logic [7:0] hist[$];

    function automatic bit legal(input logic [3:0] pat);
        int v;
        v = int'(pat);
        return (v != 0) && ((v & (v + 1)) == 0);
    endfunction

    function automatic logic [1:0] code_of(input logic [3:0] pat);
        int ones;
        ones = 0;
        for (int i = 0; i < 4; i++) ones += int'(pat[i]);
        return 2'(ones - 1);
    endfunction

    task automatic model_step();
        logic [3:0] n, p;
        bit acc;
        n = ~bus_if.nsel_inb;
        p = bus_if.psel_in;
        m_vld = 1'b0;
        if (reset) begin
            m_n = 2'b00; m_p = 2'b00;
            m_te = 1'b0; m_nm = 1'b0; m_to = 1'b0;
            m_active = 1'b0; m_done = 1'b0; m_age = 0;
            hist.delete();
        end else if (!m_active) begin
            if (bus_if.sample_req && bus_if.enable) begin
                m_active = 1'b1; m_done = 1'b0; m_age = 0;
                m_te = 1'b0; m_nm = 1'b0; m_to = 1'b0;
                hist.delete();
            end
        end else if (!bus_if.enable || m_done) begin
            m_active = 1'b0;
            m_done   = 1'b0;
        end else if (m_age < SETTLE_CYC) begin
            m_age++;
        end else begin
            hist.push_back({n, p});
            acc = (hist.size() >= STABLE_CNT);
            for (int i = 1; i < STABLE_CNT; i++)
                if (acc && hist[hist.size() - 1 - i] != hist[hist.size() - 1]) acc = 1'b0;
            if (acc) begin
                m_done = 1'b1;
                if (legal(n) && legal(p)) begin
                    m_n = code_of(n);
                    m_p = code_of(p);
                    m_vld = 1'b1;
                    m_nm = m_nm | (code_of(n) != code_of(p));
                end else begin
                    m_te = 1'b1;
                end
            end else if (hist.size() == TIMEOUT) begin
                m_to = 1'b1;
                m_active = 1'b0;
            end
        end
    endtask

    initial begin
        m_n = 0; m_p = 0; m_vld = 0; m_te = 0; m_nm = 0; m_to = 0;
        m_active = 0; m_done = 0; m_age = 0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Cycle-by-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                chk("nsel_code",   32'(bus_if.nsel_code),   32'(m_n));
                chk("psel_code",   32'(bus_if.psel_code),   32'(m_p));
                chk("code_vld",    32'(bus_if.code_vld),    32'(m_vld));
                chk("therm_err",   32'(bus_if.therm_err),   32'(m_te));
                chk("np_mismatch", 32'(bus_if.np_mismatch), 32'(m_nm));
                chk("timeout_err", 32'(bus_if.timeout_err), 32'(m_to));
                chk("busy",        32'(bus_if.busy),        32'(m_active));
            end
        end
    end

    // Pulse a request (caller sits at a negedge) and watch until busy drops.
    // act_kind: 0 none, 1 drop enable, 2 assert reset, 3 extra request.
    task automatic run_req(input int act_cyc, input int act_kind, input bit tog,
                           output int vld_cyc, output int vld_cnt, output int end_cyc);
        vld_cyc = -1; vld_cnt = 0; end_cyc = -1;
        bus_if.sample_req = 1'b1;
        @(negedge clk);
        for (int cyc = 1; cyc <= 300; cyc++) begin
            bus_if.sample_req = 1'b0;
            if (tog) bus_if.psel_in = (bus_if.psel_in == 4'b0011) ? 4'b0111 : 4'b0011;
            if (bus_if.code_vld) begin
                if (vld_cyc < 0) vld_cyc = cyc;
                vld_cnt++;
            end
            if (!bus_if.busy) begin
                end_cyc = cyc;
                break;
            end
            if (cyc == act_cyc) begin
                case (act_kind)
                    1: bus_if.enable = 1'b0;
                    2: reset = 1'b1;
                    3: bus_if.sample_req = 1'b1;
                    default: ;
                endcase
            end
            @(negedge clk);
        end
        if (end_cyc < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL run_budget busy never dropped within 300 cycles");
        end
    endtask

    int vc, vn, ec;

    initial begin
        n_cmp = 0; n_fail = 0; chk_on = 1'b0;
        reset = 1'b1;
        bus_if.enable = 1'b1; bus_if.sample_req = 1'b0;
        bus_if.nsel_inb = 4'b1111; bus_if.psel_in = 4'b0000;
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        chk("rst_outputs", {bus_if.nsel_code, bus_if.psel_code, bus_if.code_vld, bus_if.therm_err,
                            bus_if.np_mismatch, bus_if.timeout_err, bus_if.busy}, 32'd0);

        // Request in the first cycle after reset release; n=0111, p=0111.
        bus_if.nsel_inb = 4'b1000; bus_if.psel_in = 4'b0111;
        reset = 1'b0;
        run_req(0, 0, 1'b0, vc, vn, ec);
        chk("t1_vld_cyc", vc, 8);
        chk("t1_vld_cnt", vn, 1);
        chk("t1_end_cyc", ec, 9);
        chk("t1_codes", {bus_if.nsel_code, bus_if.psel_code}, 4'b1010);
        chk("t1_flags", {bus_if.therm_err, bus_if.np_mismatch, bus_if.timeout_err}, 3'b000);

        // Illegal p pattern: therm_err, codes held.
        bus_if.psel_in = 4'b0101;
        run_req(0, 0, 1'b0, vc, vn, ec);
        chk("t2_vld_cnt", vn, 0);
        chk("t2_therm_err", bus_if.therm_err, 1);
        chk("t2_codes", {bus_if.nsel_code, bus_if.psel_code}, 4'b1010);
        bus_if.psel_in = 4'b0111;
        run_req(0, 0, 1'b0, vc, vn, ec);
        chk("t2b_therm_err", bus_if.therm_err, 0);
        chk("t2b_vld_cnt", vn, 1);

        // n code 01 against p code 11.
        bus_if.nsel_inb = 4'b1100; bus_if.psel_in = 4'b1111;
        run_req(0, 0, 1'b0, vc, vn, ec);
        chk("t3_vld_cyc", vc, 8);
        chk("t3_codes", {bus_if.nsel_code, bus_if.psel_code}, 4'b0111);
        chk("t3_np_mismatch", bus_if.np_mismatch, 1);

        // p toggling every cycle never stabilises: timeout after 64 FILTER cycles.
        bus_if.nsel_inb = 4'b1000; bus_if.psel_in = 4'b0011;
        run_req(0, 0, 1'b1, vc, vn, ec);
        chk("t4_end_cyc", ec, 1 + SETTLE_CYC + TIMEOUT);
        chk("t4_vld_cnt", vn, 0);
        chk("t4_timeout_err", bus_if.timeout_err, 1);
        chk("t4_codes", {bus_if.nsel_code, bus_if.psel_code}, 4'b0111);
        bus_if.psel_in = 4'b0111;

        // Enable dropped during SETTLE.
        run_req(2, 1, 1'b0, vc, vn, ec);
        chk("t5_end_cyc", ec, 3);
        chk("t5_vld_cnt", vn, 0);
        chk("t5_codes", {bus_if.nsel_code, bus_if.psel_code}, 4'b0111);
        bus_if.enable = 1'b1;
        @(negedge clk);

        // Request with enable low in IDLE is ignored.
        bus_if.enable = 1'b0; bus_if.sample_req = 1'b1;
        @(negedge clk);
        bus_if.sample_req = 1'b0; bus_if.enable = 1'b1;
        chk("t5b_busy", bus_if.busy, 0);
        @(negedge clk);

        // Reset asserted in FILTER.
        run_req(6, 2, 1'b0, vc, vn, ec);
        chk("t6_end_cyc", ec, 7);
        chk("t6_vld_cnt", vn, 0);
        chk("t6_outputs", {bus_if.nsel_code, bus_if.psel_code, bus_if.code_vld, bus_if.therm_err,
                           bus_if.np_mismatch, bus_if.timeout_err, bus_if.busy}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Second request while busy is dropped.
        run_req(3, 3, 1'b0, vc, vn, ec);
        chk("t7_vld_cnt", vn, 1);
        chk("t7_vld_cyc", vc, 8);
        chk("t7_end_cyc", ec, 9);
        chk("t7_codes", {bus_if.nsel_code, bus_if.psel_code}, 4'b1010);
        repeat (12) @(negedge clk);
        chk("t7_idle_after", bus_if.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
